// File: rtl/img_mem_arbiter.sv
// Two-port round-robin arbiter for the 16Kx8 image memory, with bounded lock bursts; IMG_ARB_PRIO0_EN selects req0 priority with a req1 starvation guard.
// Latency: grant combinational at T, memory address/strobe at T+1, read data at T+2; one access per cycle.
// Backpressure: a requester holds req/addr/we/wdata until its gnt; rvalid cannot be stalled.
module img_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last;
  logic             last_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             lock_done;
  logic             idle_pick1;

  logic             p1_vld;
  logic             p1_id;
  logic             p1_rd;
  logic             p2_vld;
  logic             cap0;
  logic             cap1;

`ifdef IMG_ARB_PRIO0_EN
  logic [3:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (gnt1) begin
      starve_cnt <= 4'd0;
    end else if (req1 && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Requester 0 wins ties unless requester 1 has waited long enough.
  assign idle_pick1 = (starve_cnt == 4'hF);
`else
  assign idle_pick1 = ~last;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 && req1) begin
          gnt1 = idle_pick1;
          gnt0 = ~idle_pick1;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      S_OWN0:  gnt0 = req0;
      S_OWN1:  gnt1 = req1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
    // A grant during reset would be dropped by the pipeline, so never show one.
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign lock_cnt_inc = lock_cnt + CNT_W'(1);
  assign lock_done    = (lock_cnt_inc == CNT_W'(MAX_LOCK));

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;
    case (state)
      S_IDLE: begin
        if (gnt0) begin
          last_nxt = 1'b0;
          if (lock0) begin
            state_nxt    = S_OWN0;
            lock_cnt_nxt = CNT_W'(1);
          end
        end else if (gnt1) begin
          last_nxt = 1'b1;
          if (lock1) begin
            state_nxt    = S_OWN1;
            lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      S_OWN0: begin
        last_nxt = 1'b0;
        if (!req0 || !lock0 || lock_done) begin
          state_nxt    = S_IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt_inc;
        end
      end
      S_OWN1: begin
        last_nxt = 1'b1;
        if (!req1 || !lock1 || lock_done) begin
          state_nxt    = S_IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt_inc;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Stage 1: registered memory command plus its {valid, id, is-read} tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      p1_vld    <= 1'b0;
      p1_id     <= 1'b0;
      p1_rd     <= 1'b0;
    end else begin
      p1_vld  <= gnt0 | gnt1;
      p1_id   <= gnt1;
      p1_rd   <= (gnt0 & ~we0) | (gnt1 & ~we1);
      mem_wen <= (gnt0 & we0) | (gnt1 & we1);
      if (gnt1) begin
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
      end else if (gnt0) begin
        mem_addr  <= addr0;
        mem_wdata <= wdata0;
      end
    end
  end

  assign cap0 = p1_vld & p1_rd & ~p1_id;
  assign cap1 = p1_vld & p1_rd &  p1_id;

  // Stage 2: read data returns to the port named by the tag; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p2_vld  <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      p2_vld  <= p1_vld;
      rvalid0 <= cap0;
      rvalid1 <= cap1;
      if (cap0) begin
        rdata0 <= mem_rdata;
      end
      if (cap1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

  assign busy = gnt0 | gnt1 | p1_vld | p2_vld;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter: reset, streaming reads, round-robin, lock bursts, writes, reset abort.
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, lock0, we0;
  logic [13:0] addr0;
  logic [7:0]  wdata0;
  logic        gnt0, rvalid0;
  logic [7:0]  rdata0;
  logic        req1, lock1, we1;
  logic [13:0] addr1;
  logic [7:0]  wdata1;
  logic        gnt1, rvalid1;
  logic [7:0]  rdata1;
  logic [13:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Memory model: a few preloaded pixels plus the most recent write.
  logic        wr_vld = 1'b0;
  logic [13:0] wr_addr = '0;
  logic [7:0]  wr_dat = '0;

  always @(posedge clk) begin
    if (mem_wen) begin
      wr_vld  <= 1'b1;
      wr_addr <= mem_addr;
      wr_dat  <= mem_wdata;
    end
  end

  always_comb begin
    case (mem_addr)
      14'h0081: mem_rdata = 8'h5A;
      14'h0102: mem_rdata = 8'h11;
      14'h0203: mem_rdata = 8'h22;
      default:  mem_rdata = 8'h00;
    endcase
    if (wr_vld && (mem_addr == wr_addr)) mem_rdata = wr_dat;
  end

  img_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b1; lock0 = 1'b0; we0 = 1'b0; addr0 = 14'h0081; wdata0 = 8'h00;
    req1 = 1'b1; lock1 = 1'b0; we1 = 1'b0; addr1 = 14'h0102; wdata1 = 8'h00;

    // Reset held for two edges with both requests high.
    tick();
    tick();
    #3;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    reset = 1'b1;
    #1;
    check("first_tie_gnt0", gnt0, 1);
    check("first_tie_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #3;
    check("first_mem_addr", mem_addr, 14'h0081);
    check("first_busy", busy, 1);
    tick();
    #3;
    check("first_rvalid0", rvalid0, 1);
    check("first_rdata0", rdata0, 8'h5A);
    check("first_rvalid1", rvalid1, 0);
    tick();

    // Continuous reads from requester 0 alone.
    req0 = 1'b1; addr0 = 14'h0081;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("stream_gnt0", gnt0, 1);
      check("stream_gnt1", gnt1, 0);
      if (i >= 1) check("stream_mem_addr", mem_addr, 14'h0081);
      if (i >= 2) begin
        check("stream_rvalid0", rvalid0, 1);
        check("stream_rdata0", rdata0, 8'h5A);
      end
      check("stream_rvalid1", rvalid1, 0);
      tick();
    end
    req0 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #3;
      check("stream_drain_rvalid0", rvalid0, 1);
      tick();
    end
    #3;
    check("stream_end_rvalid0", rvalid0, 0);
    check("stream_end_busy", busy, 0);
    tick();

    // Both reading without lock; last=0 so requester 1 wins first.
    req0 = 1'b1; addr0 = 14'h0102;
    req1 = 1'b1; addr1 = 14'h0203;
    for (int i = 0; i < 6; i++) begin
      logic w;
      w = (i % 2 == 0);
      #3;
      check("rr_gnt1", gnt1, w);
      check("rr_gnt0", gnt0, !w);
      if (i >= 2) begin
        check("rr_rvalid1", rvalid1, w);
        check("rr_rvalid0", rvalid0, !w);
        if (w) check("rr_rdata1", rdata1, 8'h22);
        else   check("rr_rdata0", rdata0, 8'h11);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #3;
    check("rr_drain_rvalid1", rvalid1, 1);
    tick();
    #3;
    check("rr_drain_rvalid0", rvalid0, 1);
    check("rr_drain_rdata0", rdata0, 8'h11);
    tick();
    tick();

    // One grant to requester 1 so requester 0 wins the next tie.
    req1 = 1'b1;
    #3;
    check("pre_lock_gnt1", gnt1, 1);
    tick();

    // Locked burst: 9 grants to 0, then 1, then 0 locks again, released at i=12.
    req0 = 1'b1; lock0 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      logic e0;
      e0 = (i != 9) && (i != 13);
      if (i == 12) lock0 = 1'b0;
      #3;
      check("lock_gnt0", gnt0, e0);
      check("lock_gnt1", gnt1, !e0);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    tick();

    // Write of 0xC3 to the last address, then read it back.
    req1 = 1'b1; we1 = 1'b1; addr1 = 14'h3FFF; wdata1 = 8'hC3;
    #3;
    check("wr_gnt1", gnt1, 1);
    check("wr_gnt0", gnt0, 0);
    tick();
    req1 = 1'b0; we1 = 1'b0;
    #3;
    check("wr_mem_wen", mem_wen, 1);
    check("wr_mem_addr", mem_addr, 14'h3FFF);
    check("wr_mem_wdata", mem_wdata, 8'hC3);
    check("wr_busy", busy, 1);
    tick();
    #3;
    check("wr_mem_wen_off", mem_wen, 0);
    check("wr_rvalid0", rvalid0, 0);
    check("wr_rvalid1", rvalid1, 0);
    check("wr_busy_p2", busy, 1);
    tick();
    #3;
    check("wr_rvalid1_late", rvalid1, 0);
    check("wr_busy_idle", busy, 0);
    req1 = 1'b1;
    #1;
    check("rb_gnt1", gnt1, 1);
    tick();
    req1 = 1'b0;
    tick();
    #3;
    check("rb_rvalid1", rvalid1, 1);
    check("rb_rdata1", rdata1, 8'hC3);
    tick();

    // Read granted, then reset the next cycle: its rvalid must never appear.
    req0 = 1'b1; addr0 = 14'h0081;
    #3;
    check("abort_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    #3;
    check("abort_rvalid0", rvalid0, 0);
    check("abort_busy", busy, 0);
    check("abort_mem_addr", mem_addr, 0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("post_rst_gnt0", gnt0, 1);
    check("post_rst_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #3;
    check("post_rst_rvalid0_gap", rvalid0, 0);
    tick();
    #3;
    check("post_rst_rvalid0", rvalid0, 1);
    check("post_rst_rdata0", rdata0, 8'h5A);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
